// File: rtl/booth_div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int WIDTH_DEF = 6;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division step on unsigned magnitudes.
module div_step #(
    parameter int width = 6
) (
    input  logic [width:0] rem_i,
    input  logic [width:0] dvs_i,
    input  logic           bit_i,
    output logic [width:0] rem_o,
    output logic           q_o
);

    logic [width+1:0] shifted;
    logic [width+1:0] diff;
    logic [width+1:0] nxt;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, dvs_i};
        q_o     = ~diff[width+1];
        nxt     = q_o ? diff : shifted;
        // Partial remainder stays below the divisor, so the top bit is always zero.
        rem_o   = (width+1)'(nxt);
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on magnitudes, then sign fix.
module booth_div
    import booth_div_pkg::*;
#(
    parameter int width = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quo,
    output logic [width-1:0] rem,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = cnt_w(width);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [width:0]   prem_q;
    logic [width:0]   dvs_q;
    logic [width-1:0] dvd_q;
    logic [width-1:0] a_q;
    logic             sa_q, sb_q, dz_q;
    logic             busy_q, done_q, dz_out_q, ovf_q;
    logic [width-1:0] quo_q, rem_q;

    logic [width:0]   step_rem;
    logic             step_q;
    logic             last_step, zero_in2, q_neg, q_max;
    logic [width-1:0] rmag;

    div_step #(.width(width)) u_step (
        .rem_i (prem_q),
        .dvs_i (dvs_q),
        .bit_i (dvd_q[width-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign last_step = (cnt_q == CW'(width - 1));
    assign zero_in2  = (in2 == '0);
    assign q_neg     = sa_q ^ sb_q;
    assign rmag      = prem_q[width-1:0];
    assign q_max     = (dvd_q == {1'b1, {(width-1){1'b0}}});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zero_in2 ? FIX : CALC;
            CALC:    if (last_step) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            prem_q   <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_out_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q  <= '0;
                        prem_q <= '0;
                        a_q    <= in1;
                        sa_q   <= in1[width-1];
                        sb_q   <= in2[width-1];
                        dz_q   <= zero_in2;
                        dvd_q  <= in1[width-1] ? -in1 : in1;
                        dvs_q  <= {1'b0, (in2[width-1] ? -in2 : in2)};
                    end
                end
                CALC: begin
                    prem_q <= step_rem;
                    dvd_q  <= {dvd_q[width-2:0], step_q};
                    cnt_q  <= cnt_q + 1'b1;
                end
                FIX: begin
                    if (dz_q) begin
                        quo_q    <= '1;
                        rem_q    <= a_q;
                        dz_out_q <= 1'b1;
                        ovf_q    <= 1'b0;
                    end else begin
                        quo_q    <= q_neg ? -dvd_q : dvd_q;
                        dz_out_q <= 1'b0;
                        ovf_q    <= q_max & ~q_neg;
                        if (q_max & ~q_neg) rem_q <= '0;
                        else                rem_q <= sa_q ? -rmag : rmag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quo      = quo_q;
    assign rem      = rem_q;
    assign div_zero = dz_out_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_booth_div.sv
// Directed self-checking bench for booth_div at width 6.
module tb_booth_div;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1, in2;
    logic         busy, done;
    logic [W-1:0] quo, rem;
    logic         div_zero, ovf;

    int errors = 0;
    int checks = 0;

    booth_div #(.width(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start at a time just after a rising edge and waits (bounded) for done.
    // cyc = 1 is the cycle right after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int cyc, output bit busy_ok);
        in1 = a;
        in2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = busy;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quo, rem, div_zero, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {busy, done, quo, rem, div_zero, ovf});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc;
        bit bok;
        do_op(6'd27, 6'd5, cyc, bok);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL basic_latency got=%0d want=8", cyc); end
        checks++;
        if (!bok) begin errors++; $display("FAIL basic_busy got=gap want=continuous"); end
        checks++;
        if (quo !== 6'd5 || rem !== 6'd2 || div_zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_27_5 got quo=%b rem=%b dz=%b ovf=%b want quo=000101 rem=000010 dz=0 ovf=0",
                     quo, rem, div_zero, ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (quo !== 6'd5 || rem !== 6'd2) begin
            errors++;
            $display("FAIL hold got quo=%b rem=%b want 000101 000010", quo, rem);
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] va [4] = '{6'b100101, 6'd27,     6'b100101, 6'd31};
        logic [W-1:0] vb [4] = '{6'd5,      6'b111011, 6'b111011, 6'b100000};
        logic [W-1:0] eq [4] = '{6'b111011, 6'b111011, 6'd5,      6'd0};
        logic [W-1:0] er [4] = '{6'b111110, 6'd2,      6'b111110, 6'd31};
        int cyc;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], cyc, bok);
            checks++;
            if (cyc !== 8 || quo !== eq[i] || rem !== er[i] || ovf !== 1'b0 || div_zero !== 1'b0) begin
                errors++;
                $display("FAIL signs_%0d got cyc=%0d quo=%b rem=%b ovf=%b dz=%b want cyc=8 quo=%b rem=%b ovf=0 dz=0",
                         i, cyc, quo, rem, ovf, div_zero, eq[i], er[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overflow();
        int cyc;
        bit bok;
        do_op(6'b100000, 6'b111111, cyc, bok);
        checks++;
        if (quo !== 6'b100000 || rem !== 6'd0 || ovf !== 1'b1 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_m32_m1 got quo=%b rem=%b ovf=%b dz=%b want 100000 000000 1 0",
                     quo, rem, ovf, div_zero);
        end
        @(posedge clk);
        #1;
        do_op(6'b100000, 6'd1, cyc, bok);
        checks++;
        if (quo !== 6'b100000 || rem !== 6'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_m32_p1 got quo=%b rem=%b ovf=%b want 100000 000000 0", quo, rem, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_zero();
        int cyc;
        bit bok;
        do_op(6'd13, 6'd0, cyc, bok);
        checks++;
        if (cyc !== 2 || !bok) begin
            errors++;
            $display("FAIL dz_latency got cyc=%0d busy_ok=%0d want 2 1", cyc, bok);
        end
        checks++;
        if (quo !== 6'b111111 || rem !== 6'd13 || div_zero !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL dz_result got quo=%b rem=%b dz=%b ovf=%b want 111111 001101 1 0",
                     quo, rem, div_zero, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int  cyc;
        bit  bok;
        in1 = 6'd27;
        in2 = 6'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        bok = busy;
        while (!done && cyc < 40) begin
            if (cyc == 3) begin
                in1 = 6'd10;
                in2 = 6'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!busy) bok = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (cyc !== 8 || !bok) begin
            errors++;
            $display("FAIL ignore_timing got cyc=%0d busy_ok=%0d want 8 1", cyc, bok);
        end
        checks++;
        if (quo !== 6'd5 || rem !== 6'd2) begin
            errors++;
            $display("FAIL ignore_result got quo=%b rem=%b want 000101 000010", quo, rem);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_midreset();
        int cyc;
        bit bok;
        in1 = 6'd27;
        in2 = 6'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quo, rem, div_zero, ovf} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b want=0", {busy, done, quo, rem, div_zero, ovf});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(6'b100101, 6'd5, cyc, bok);
        checks++;
        if (cyc !== 8 || quo !== 6'b111011 || rem !== 6'b111110) begin
            errors++;
            $display("FAIL midreset_recover got cyc=%0d quo=%b rem=%b want 8 111011 111110", cyc, quo, rem);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok;
        do_op(6'd27, 6'd5, cyc, bok);
        in1 = 6'b100101;
        in2 = 6'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
        end
        do_op(6'b100101, 6'd5, cyc, bok);
        checks++;
        if (cyc !== 8 || !bok || quo !== 6'b111011 || rem !== 6'b111110) begin
            errors++;
            $display("FAIL b2b_second got cyc=%0d busy_ok=%0d quo=%b rem=%b want 8 1 111011 111110",
                     cyc, bok, quo, rem);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_start_ignored();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
